// File: rtl/updown_sweep_counter.sv
// Triangle sweep counter: counts 0 -> lim -> 0 for PASSES passes, or until stop when PASSES=0.
// Optional `SWEEP_HOLD_EN` adds a hold input that freezes an active sweep.
module updown_sweep_counter #(
  parameter int unsigned N      = 2,
  parameter int unsigned PASSES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] limit,
`ifdef SWEEP_HOLD_EN
  input  logic         hold,
`endif
  output logic [N-1:0] out,
  output logic         dir,
  output logic         busy,
  output logic         peak,
  output logic         done
);

  localparam int unsigned PW = (PASSES < 2) ? 1 : $clog2(PASSES);
  localparam logic [PW-1:0] LastPass = PW'((PASSES == 0) ? 0 : PASSES - 1);
  localparam logic [N-1:0]  One      = N'(1);

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    out_q, out_d;
  logic [N-1:0]    lim_q, lim_d;
  logic [PW-1:0]   pass_q, pass_d;
  logic            dir_q, dir_d;
  logic            busy_q, busy_d;
  logic            peak_q, peak_d;
  logic            done_q, done_d;
  logic            frz;
  logic            eop;

`ifdef SWEEP_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    lim_d   = lim_q;
    pass_d  = pass_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    peak_d  = 1'b0;
    done_d  = 1'b0;
    eop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          if (limit != '0) begin
            lim_d   = limit;
            pass_d  = '0;
            out_d   = '0;
            dir_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = StUp;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StUp: begin
        if (stop) begin
          state_d = StIdle;
          out_d   = '0;
          dir_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (!frz) begin
          if (out_q != lim_q) begin
            out_d = out_q + One;
          end else begin
            out_d  = lim_q - One;
            peak_d = 1'b1;
            if (lim_q != One) begin
              state_d = StDown;
              dir_d   = 1'b1;
            end else begin
              eop = 1'b1;
            end
          end
        end
      end
      StDown: begin
        if (stop) begin
          state_d = StIdle;
          out_d   = '0;
          dir_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (!frz) begin
          if (out_q == One) begin
            eop = 1'b1;
          end else begin
            out_d = out_q - One;
          end
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = '0;
        dir_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Passes share the out=0 sample, so the next pass starts with no gap
    if (eop) begin
      out_d = '0;
      dir_d = 1'b0;
      if ((PASSES != 0) && (pass_q == LastPass)) begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        pass_d  = pass_q + 1'b1;
        state_d = StUp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      lim_q   <= '0;
      pass_q  <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      peak_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      lim_q   <= lim_d;
      pass_q  <= pass_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      peak_q  <= peak_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign dir  = dir_q;
  assign busy = busy_q;
  assign peak = peak_q;
  assign done = done_q;

endmodule

// File: tb/tb_updown_sweep_counter.sv
// Directed bench for updown_sweep_counter: three instances with PASSES = 1, 2 and 0.
// Vectors are packed as {out[1:0], dir, busy, peak, done}.
module tb_updown_sweep_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic       stop_a = 1'b0, stop_b = 1'b0, stop_c = 1'b0;
  logic [1:0] limit = 2'd0;
`ifdef SWEEP_HOLD_EN
  logic       hold = 1'b0;
`endif

  logic [1:0] out_a, out_b, out_c;
  logic       dir_a, dir_b, dir_c;
  logic       busy_a, busy_b, busy_c;
  logic       peak_a, peak_b, peak_c;
  logic       done_a, done_b, done_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  updown_sweep_counter #(.N(2), .PASSES(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .limit(limit),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .out(out_a), .dir(dir_a), .busy(busy_a), .peak(peak_a), .done(done_a)
  );

  updown_sweep_counter #(.N(2), .PASSES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .limit(limit),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .out(out_b), .dir(dir_b), .busy(busy_b), .peak(peak_b), .done(done_b)
  );

  updown_sweep_counter #(.N(2), .PASSES(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .stop(stop_c), .limit(limit),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .out(out_c), .dir(dir_c), .busy(busy_c), .peak(peak_c), .done(done_c)
  );

  logic [5:0] vec_a, vec_b, vec_c;
  assign vec_a = {out_a, dir_a, busy_a, peak_a, done_a};
  assign vec_b = {out_b, dir_b, busy_b, peak_b, done_b};
  assign vec_c = {out_c, dir_c, busy_c, peak_c, done_c};

  function automatic logic [5:0] v(input logic [1:0] o, input logic d, input logic b,
                                   input logic p, input logic dn);
    return {o, d, b, p, dn};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp1 [8];
  logic [5:0] exp2 [6];
  logic [1:0] tri_out [6];
  logic [5:0] exph [11];

  initial begin
    exp1 = '{v(0,0,1,0,0), v(1,0,1,0,0), v(2,0,1,0,0), v(3,0,1,0,0),
             v(2,1,1,1,0), v(1,1,1,0,0), v(0,0,0,0,1), v(0,0,0,0,0)};
    exp2 = '{v(0,0,1,0,0), v(1,0,1,0,0), v(0,0,1,1,0), v(1,0,1,0,0),
             v(0,0,0,1,1), v(0,0,0,0,0)};
    tri_out = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
    exph = '{v(0,0,1,0,0), v(1,0,1,0,0), v(2,0,1,0,0), v(3,0,1,0,0),
             v(3,0,1,0,0), v(3,0,1,0,0), v(3,0,1,0,0), v(2,1,1,1,0),
             v(1,1,1,0,0), v(0,0,0,0,1), v(0,0,0,0,0)};

    // Reset
    tick;
    tick;
    rst = 1'b0;
    check_eq("reset_a", vec_a, 6'd0);
    check_eq("reset_b", vec_b, 6'd0);
    check_eq("reset_c", vec_c, 6'd0);

    // Single pass, limit 3
    limit   = 2'd3;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("sweep3_%0d", i), vec_a, exp1[i]);
      tick;
    end

    // Start ignored while busy, limit change ignored
    limit   = 2'd3;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    limit   = 2'd1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check_eq("busy_restart_out", vec_a, v(1,0,1,0,0));
    tick;
    check_eq("busy_limit_hold", vec_a, v(2,0,1,0,0));
    for (int i = 0; i < 5; i++) tick;
    check_eq("busy_restart_end", vec_a, v(0,0,0,0,0));

    // Two passes, limit 1
    limit   = 2'd1;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("lim1_%0d", i), vec_b, exp2[i]);
      tick;
    end

    // limit 0: no sweep, done on next cycle
    limit   = 2'd0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    check_eq("lim0_done", vec_a, v(0,0,0,0,1));
    tick;
    check_eq("lim0_after", vec_a, v(0,0,0,0,0));

    // Stop at out=2 in DOWN
    limit   = 2'd3;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    check_eq("stop_pre", vec_a, v(2,1,1,1,0));
    stop_a = 1'b1;
    tick;
    stop_a = 1'b0;
    check_eq("stop_abort", vec_a, v(0,0,0,0,0));
    tick;
    check_eq("stop_no_done", vec_a, v(0,0,0,0,0));

    // start + stop together in IDLE
    start_a = 1'b1;
    stop_a  = 1'b1;
    tick;
    start_a = 1'b0;
    stop_a  = 1'b0;
    check_eq("start_stop_idle", vec_a, v(0,0,0,0,0));
    tick;
    check_eq("start_stop_idle2", vec_a, v(0,0,0,0,0));

    // Continuous sweep, limit 3
    limit   = 2'd3;
    start_c = 1'b1;
    tick;
    start_c = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("cont_out_%0d", i), {30'd0, out_c}, {30'd0, tri_out[i % 6]});
      check_eq($sformatf("cont_ctl_%0d", i), {29'd0, busy_c, peak_c, done_c},
               {29'd0, 1'b1, (i % 6) == 4, 1'b0});
      tick;
    end
    check_eq("cont_mid", vec_c, v(2,0,1,0,0));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("cont_rst", vec_c, 6'd0);

`ifdef SWEEP_HOLD_EN
    // Hold for 3 cycles at out=3
    limit   = 2'd3;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("hold_%0d", i), vec_a, exph[i]);
      hold = (i >= 3) && (i <= 5);
      tick;
    end
    hold = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
